// File: rtl/datapath.sv
// Single-bus 32-bit CPU datapath: PC, IR, MAR, MDR, Y, Z (Lo/Hi), general
// registers R3/R4/R5/R7 and an ALU, all sharing one bus. An external control
// sequencer moves data between them, one cycle at a time, through the *in/*out strobes.
//
// Ports
//   clock              rising-edge clock for all state
//   clear              asynchronous active-high reset; sets every register to 0
//   PCout/PCin/IncPC   PC drive / load / force ALU result to bus+1
//   MARin/MARout       MAR load / drive
//   MDRin/MDRout       MDR load / drive
//   MDRread            MDR D-input selects Mdatain instead of the bus
//   IRin/IRout         IR load / drive
//   RYin/RYout         Y load / drive
//   RZinLo/RZoutLo     load Z from the ALU / drive Z[31:0]
//   R3..R7 in/out      general register load / drive
//   Mdatain            memory read data
//   BusMuxOut          combinational view of the shared bus
//
// Configuration
//   DATAPATH_MULDIV_EN  when defined, adds signed multiply (op 15) and signed
//                       divide (op 16) with a 64-bit Z result. When undefined,
//                       ops 15/16 decode as add and Z[63:32] is always 0.
module datapath #(
  parameter int unsigned W       = 32,
  parameter int unsigned OPC_NEG = 17
) (
  input  logic         clock,
  input  logic         clear,
  input  logic         PCout,
  input  logic         PCin,
  input  logic         IncPC,
  input  logic         MARin,
  input  logic         MARout,
  input  logic         MDRin,
  input  logic         MDRout,
  input  logic         MDRread,
  input  logic         IRin,
  input  logic         IRout,
  input  logic         RYin,
  input  logic         RYout,
  input  logic         RZinLo,
  input  logic         RZoutLo,
  input  logic         R3in,
  input  logic         R3out,
  input  logic         R4in,
  input  logic         R4out,
  input  logic         R5in,
  input  logic         R5out,
  input  logic         R7in,
  input  logic         R7out,
  input  logic [W-1:0] Mdatain,
  output logic [W-1:0] BusMuxOut
);

  localparam int unsigned OPW = 5;
  localparam int unsigned SHW = $clog2(W);

  localparam logic [OPW-1:0] OP_ADD = 5'd3;
  localparam logic [OPW-1:0] OP_SUB = 5'd4;
  localparam logic [OPW-1:0] OP_SHR = 5'd5;
  localparam logic [OPW-1:0] OP_SHL = 5'd6;
  localparam logic [OPW-1:0] OP_ROR = 5'd7;
  localparam logic [OPW-1:0] OP_ROL = 5'd8;
  localparam logic [OPW-1:0] OP_AND = 5'd9;
  localparam logic [OPW-1:0] OP_OR  = 5'd10;
  localparam logic [OPW-1:0] OP_NOT = 5'd18;
  localparam logic [OPW-1:0] OP_NEG = OPW'(OPC_NEG);
`ifdef DATAPATH_MULDIV_EN
  localparam logic [OPW-1:0] OP_MUL = 5'd15;
  localparam logic [OPW-1:0] OP_DIV = 5'd16;
`endif

  logic [W-1:0] pc, ir, mar, mdr, ry, z_lo;
  logic [W-1:0] r3, r4, r5, r7;
`ifdef DATAPATH_MULDIV_EN
  logic [W-1:0] z_hi;
`endif

  // Shared bus: fixed-priority mux, idle bus reads as 0
  always_comb begin
    BusMuxOut = '0;
    if      (PCout)   BusMuxOut = pc;
    else if (RZoutLo) BusMuxOut = z_lo;
    else if (MDRout)  BusMuxOut = mdr;
    else if (MARout)  BusMuxOut = mar;
    else if (IRout)   BusMuxOut = ir;
    else if (RYout)   BusMuxOut = ry;
    else if (R3out)   BusMuxOut = r3;
    else if (R4out)   BusMuxOut = r4;
    else if (R5out)   BusMuxOut = r5;
    else if (R7out)   BusMuxOut = r7;
  end

  // ALU: A = Y, B = bus, operation from the IR opcode field
  logic [OPW-1:0]   opcode;
  logic [W-1:0]     alu_a, alu_b, alu_lo;
  logic [SHW-1:0]   sh;
  logic [2*W-1:0]   rot_buf, rol_buf;
  logic [W-1:0]     ror_res, rol_res;

  assign opcode  = ir[W-1 -: OPW];
  assign alu_a   = ry;
  assign alu_b   = BusMuxOut;
  assign sh      = alu_b[SHW-1:0];
  // Rotates shift a doubled copy of A so the bits leaving one end reappear at the other
  assign rot_buf = {alu_a, alu_a};
  assign ror_res = W'(rot_buf >> sh);
  assign rol_buf = rot_buf << sh;
  assign rol_res = rol_buf[2*W-1:W];

`ifdef DATAPATH_MULDIV_EN
  logic [W-1:0]          alu_hi;
  logic signed [2*W-1:0] prod;
  logic signed [W-1:0]   quot, rem;
  assign prod = $signed({{W{alu_a[W-1]}}, alu_a}) * $signed({{W{alu_b[W-1]}}, alu_b});
  // Divide by zero yields 0 in both halves rather than an undefined value
  assign quot = (alu_b == '0) ? '0 : $signed(alu_a) / $signed(alu_b);
  assign rem  = (alu_b == '0) ? '0 : $signed(alu_a) % $signed(alu_b);
`endif

  always_comb begin
    alu_lo = alu_a + alu_b;
`ifdef DATAPATH_MULDIV_EN
    alu_hi = '0;
`endif
    if (IncPC) begin
      alu_lo = alu_b + W'(1);
    end else begin
      case (opcode)
        OP_ADD:  alu_lo = alu_a + alu_b;
        OP_SUB:  alu_lo = alu_a - alu_b;
        OP_SHR:  alu_lo = alu_a >> sh;
        OP_SHL:  alu_lo = alu_a << sh;
        OP_ROR:  alu_lo = ror_res;
        OP_ROL:  alu_lo = rol_res;
        OP_AND:  alu_lo = alu_a & alu_b;
        OP_OR:   alu_lo = alu_a | alu_b;
        OP_NEG:  alu_lo = W'(0) - alu_b;
        OP_NOT:  alu_lo = ~alu_b;
`ifdef DATAPATH_MULDIV_EN
        OP_MUL: begin
          alu_lo = prod[W-1:0];
          alu_hi = prod[2*W-1:W];
        end
        OP_DIV: begin
          alu_lo = quot;
          alu_hi = rem;
        end
`endif
        default: alu_lo = alu_a + alu_b;
      endcase
    end
  end

  // Register file: each register captures its D-input on its own strobe.
  // In the default build Z[63:32] is constantly zero with no reader, so it is not stored.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      pc   <= '0;
      ir   <= '0;
      mar  <= '0;
      mdr  <= '0;
      ry   <= '0;
      z_lo <= '0;
      r3   <= '0;
      r4   <= '0;
      r5   <= '0;
      r7   <= '0;
`ifdef DATAPATH_MULDIV_EN
      z_hi <= '0;
`endif
    end else begin
      if (PCin)  pc  <= BusMuxOut;
      if (IRin)  ir  <= BusMuxOut;
      if (MARin) mar <= BusMuxOut;
      if (MDRin) mdr <= MDRread ? Mdatain : BusMuxOut;
      if (RYin)  ry  <= BusMuxOut;
      if (R3in)  r3  <= BusMuxOut;
      if (R4in)  r4  <= BusMuxOut;
      if (R5in)  r5  <= BusMuxOut;
      if (R7in)  r7  <= BusMuxOut;
      if (RZinLo) begin
        z_lo <= alu_lo;
`ifdef DATAPATH_MULDIV_EN
        z_hi <= alu_hi;
`endif
      end
    end
  end

endmodule

// File: tb/tb_datapath.sv
// Directed bench for datapath: a table of one-cycle control vectors with the
// expected bus value, an opcode sweep, and hand-written asynchronous-clear sequences.
module tb_datapath;

  localparam int unsigned NC = 22;

  localparam logic [NC-1:0] M_PCOUT   = 22'd1 << 0;
  localparam logic [NC-1:0] M_PCIN    = 22'd1 << 1;
  localparam logic [NC-1:0] M_INCPC   = 22'd1 << 2;
  localparam logic [NC-1:0] M_MARIN   = 22'd1 << 3;
  localparam logic [NC-1:0] M_MAROUT  = 22'd1 << 4;
  localparam logic [NC-1:0] M_MDRIN   = 22'd1 << 5;
  localparam logic [NC-1:0] M_MDROUT  = 22'd1 << 6;
  localparam logic [NC-1:0] M_MDRREAD = 22'd1 << 7;
  localparam logic [NC-1:0] M_IRIN    = 22'd1 << 8;
  localparam logic [NC-1:0] M_IROUT   = 22'd1 << 9;
  localparam logic [NC-1:0] M_RYIN    = 22'd1 << 10;
  localparam logic [NC-1:0] M_RYOUT   = 22'd1 << 11;
  localparam logic [NC-1:0] M_RZIN    = 22'd1 << 12;
  localparam logic [NC-1:0] M_RZOUT   = 22'd1 << 13;
  localparam logic [NC-1:0] M_R3IN    = 22'd1 << 14;
  localparam logic [NC-1:0] M_R3OUT   = 22'd1 << 15;
  localparam logic [NC-1:0] M_R4IN    = 22'd1 << 16;
  localparam logic [NC-1:0] M_R4OUT   = 22'd1 << 17;
  localparam logic [NC-1:0] M_R5IN    = 22'd1 << 18;
  localparam logic [NC-1:0] M_R5OUT   = 22'd1 << 19;
  localparam logic [NC-1:0] M_R7IN    = 22'd1 << 20;
  localparam logic [NC-1:0] M_R7OUT   = 22'd1 << 21;
  localparam logic [NC-1:0] M_LDMDR   = M_MDRREAD | M_MDRIN;

  logic          clock;
  logic          clear;
  logic [NC-1:0] ctrl;
  logic [31:0]   mdatain;
  logic [31:0]   bus;

  typedef struct {
    logic [NC-1:0] ctrl;
    logic [31:0]   md;
    logic [31:0]   exp_bus;
    string         name;
  } vec_t;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] exp_z;
    string       name;
  } op_vec_t;

  vec_t    vecs[$];
  op_vec_t ops[$];
  int      n_checks = 0;
  int      n_fail   = 0;

  datapath dut (
    .clock    (clock),
    .clear    (clear),
    .PCout    (ctrl[0]),
    .PCin     (ctrl[1]),
    .IncPC    (ctrl[2]),
    .MARin    (ctrl[3]),
    .MARout   (ctrl[4]),
    .MDRin    (ctrl[5]),
    .MDRout   (ctrl[6]),
    .MDRread  (ctrl[7]),
    .IRin     (ctrl[8]),
    .IRout    (ctrl[9]),
    .RYin     (ctrl[10]),
    .RYout    (ctrl[11]),
    .RZinLo   (ctrl[12]),
    .RZoutLo  (ctrl[13]),
    .R3in     (ctrl[14]),
    .R3out    (ctrl[15]),
    .R4in     (ctrl[16]),
    .R4out    (ctrl[17]),
    .R5in     (ctrl[18]),
    .R5out    (ctrl[19]),
    .R7in     (ctrl[20]),
    .R7out    (ctrl[21]),
    .Mdatain  (mdatain),
    .BusMuxOut(bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input logic [31:0] exp);
    n_checks++;
    if (bus !== exp) begin
      n_fail++;
      $display("FAIL %s: bus=%08h expected %08h", name, bus, exp);
    end
  endtask

  // One bus cycle: drive after the falling edge, compare before the rising edge
  task automatic step(input logic [NC-1:0] c, input logic [31:0] md,
                      input logic [31:0] exp, input string name);
    @(negedge clock);
    ctrl    = c;
    mdatain = md;
    #2;
    check(name, exp);
  endtask

  task automatic add(input logic [NC-1:0] c, input logic [31:0] md,
                     input logic [31:0] exp, input string name);
    vec_t v;
    v.ctrl = c; v.md = md; v.exp_bus = exp; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic add_op(input logic [4:0] op, input logic [31:0] exp, input string name);
    op_vec_t v;
    v.op = op; v.exp_z = exp; v.name = name;
    ops.push_back(v);
  endtask

  initial begin
    ctrl    = '0;
    mdatain = '0;
    clear   = 1'b1;
    #12 clear = 1'b0;

    // Reset state of every bus source
    add('0,        0, 32'h0, "reset_idle");
    add(M_PCOUT,   0, 32'h0, "reset_pc");
    add(M_RZOUT,   0, 32'h0, "reset_z");
    add(M_MDROUT,  0, 32'h0, "reset_mdr");
    add(M_MAROUT,  0, 32'h0, "reset_mar");
    add(M_IROUT,   0, 32'h0, "reset_ir");
    add(M_RYOUT,   0, 32'h0, "reset_y");
    add(M_R3OUT,   0, 32'h0, "reset_r3");
    add(M_R4OUT,   0, 32'h0, "reset_r4");
    add(M_R5OUT,   0, 32'h0, "reset_r5");
    add(M_R7OUT,   0, 32'h0, "reset_r7");
    // Memory data into MDR, then MDR to R5
    add(M_LDMDR,            32'h22, 32'h0,  "t1_ld_mdr");
    add(M_MDROUT | M_R5IN,  0,      32'h22, "t1_mdr_to_r5");
    add(M_R5OUT,            0,      32'h22, "t1_r5");
    // PC increment through Z
    add(M_PCOUT | M_INCPC | M_RZIN, 0, 32'h0, "t2_pc_inc");
    add(M_RZOUT | M_PCIN,           0, 32'h1, "t2_z_to_pc");
    add(M_PCOUT,                    0, 32'h1, "t2_pc");
    // neg instruction (opcode 17) on R5
    add(M_LDMDR,            32'h8A2B8000, 32'h0,        "t3_ld_mdr");
    add(M_MDROUT | M_IRIN,  0,            32'h8A2B8000, "t3_ir");
    add(M_R5OUT | M_RZIN,   0,            32'h22,       "t3_r5_alu");
    add(M_RZOUT | M_R5IN,   0,            32'hFFFFFFDE, "t3_z_neg");
    add(M_R5OUT,            0,            32'hFFFFFFDE, "t3_r5");
    add(M_MDROUT | M_MARIN, 0,            32'h8A2B8000, "mar_load");
    add(M_MAROUT,           0,            32'h8A2B8000, "mar");
    // add R3 + R4
    add(M_LDMDR,            32'h5,        32'h0,        "t4_ld5");
    add(M_MDROUT | M_R3IN,  0,            32'h5,        "t4_r3");
    add(M_LDMDR,            32'h7,        32'h0,        "t4_ld7");
    add(M_MDROUT | M_R4IN,  0,            32'h7,        "t4_r4");
    add(M_LDMDR,            32'h18000000, 32'h0,        "t4_ld_ir");
    add(M_MDROUT | M_IRIN,  0,            32'h18000000, "t4_ir");
    add(M_R3OUT | M_RYIN,   0,            32'h5,        "t4_y_load");
    add(M_RYOUT,            0,            32'h5,        "t4_y");
    add(M_R4OUT | M_RZIN,   0,            32'h7,        "t4_alu");
    add(M_RZOUT,            0,            32'hC,        "t4_z_add");
    // not instruction (opcode 18) on R7
    add(M_LDMDR,            32'h90000000, 32'h0,        "t5_ld_ir");
    add(M_MDROUT | M_IRIN,  0,            32'h90000000, "t5_ir");
    add(M_LDMDR,            32'h0F0F0F0F, 32'h0,        "t5_ld_r7");
    add(M_MDROUT | M_R7IN,  0,            32'h0F0F0F0F, "t5_r7");
    add(M_R7OUT | M_RZIN,   0,            32'h0F0F0F0F, "t5_alu");
    add(M_RZOUT,            0,            32'hF0F0F0F0, "t5_z_not");
    // Bus priority: PC=1 Z=F0F0F0F0 MDR=0F0F0F0F MAR=8A2B8000 IR=90000000 Y=5 R4=7 R5=FFFFFFDE
    add('1 & ~(M_PCIN | M_MARIN | M_MDRIN | M_IRIN | M_RYIN | M_RZIN | M_R3IN | M_R4IN |
               M_R5IN | M_R7IN | M_INCPC | M_MDRREAD), 0, 32'h1, "prio_pc");
    add(M_RZOUT | M_MDROUT | M_MAROUT | M_IROUT | M_RYOUT | M_R7OUT, 0, 32'hF0F0F0F0, "prio_z");
    add(M_MDROUT | M_MAROUT | M_IROUT,  0, 32'h0F0F0F0F, "prio_mdr");
    add(M_MAROUT | M_IROUT | M_RYOUT,   0, 32'h8A2B8000, "prio_mar");
    add(M_IROUT | M_RYOUT,              0, 32'h90000000, "prio_ir");
    add(M_R4OUT | M_R5OUT | M_R7OUT,    0, 32'h7,        "prio_r4");
    add(M_R5OUT | M_R7OUT,              0, 32'hFFFFFFDE, "prio_r5");
    // Load and drive the same register in one cycle
    add(M_MDROUT | M_LDMDR,  32'hDEADBEEF, 32'h0F0F0F0F, "same_old");
    add(M_MDROUT,            0,            32'hDEADBEEF, "same_new");
    // IncPC overrides the IR opcode (IR holds not)
    add(M_PCOUT | M_INCPC | M_RZIN, 0, 32'h1, "inc_over");
    add(M_RZOUT,                    0, 32'h2, "inc_over_z");
    // Y = 0x80000005 for the opcode sweep
    add(M_LDMDR,            32'h80000005, 32'h0,        "sweep_ld_y");
    add(M_MDROUT | M_RYIN,  0,            32'h80000005, "sweep_y");

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i].ctrl, vecs[i].md, vecs[i].exp_bus, vecs[i].name);

    // Opcode sweep: A = Y = 0x80000005, B = R4 = 7
    add_op(5'd3,  32'h8000000C, "op_add");
    add_op(5'd4,  32'h7FFFFFFE, "op_sub");
    add_op(5'd5,  32'h01000000, "op_shr");
    add_op(5'd6,  32'h00000280, "op_shl");
    add_op(5'd7,  32'h0B000000, "op_ror");
    add_op(5'd8,  32'h000002C0, "op_rol");
    add_op(5'd9,  32'h00000005, "op_and");
    add_op(5'd10, 32'h80000007, "op_or");
    add_op(5'd17, 32'hFFFFFFF9, "op_neg");
    add_op(5'd18, 32'hFFFFFFF8, "op_not");
    add_op(5'd0,  32'h8000000C, "op_dflt0");
    add_op(5'd31, 32'h8000000C, "op_dflt31");
`ifdef DATAPATH_MULDIV_EN
    add_op(5'd15, 32'h80000023, "op_mul");
    add_op(5'd16, 32'hEDB6DB6F, "op_div");
`else
    add_op(5'd15, 32'h8000000C, "op_15_add");
    add_op(5'd16, 32'h8000000C, "op_16_add");
`endif

    for (int i = 0; i < ops.size(); i++) begin
      logic [31:0] irw;
      irw = {ops[i].op, 27'h0};
      step(M_LDMDR,            irw, 32'h0, {ops[i].name, "_ldmdr"});
      step(M_MDROUT | M_IRIN,  0,   irw,   {ops[i].name, "_ir"});
      step(M_R4OUT | M_RZIN,   0,   32'h7, {ops[i].name, "_b"});
      step(M_RZOUT,            0,   ops[i].exp_z, ops[i].name);
    end

    // Clear pulsed between edges while R5 is loading from itself
    @(negedge clock);
    ctrl = M_R5OUT | M_R5IN;
    #1 check("clr_pre", 32'hFFFFFFDE);
    clear = 1'b1;
    #1 check("clr_async", 32'h0);
    clear = 1'b0;
    #1 check("clr_released", 32'h0);
    step(M_R5OUT,  0, 32'h0, "clr_r5");
    step(M_PCOUT,  0, 32'h0, "clr_pc");
    step(M_RZOUT,  0, 32'h0, "clr_z");
    step(M_MDROUT, 0, 32'h0, "clr_mdr");
    step(M_IROUT,  0, 32'h0, "clr_ir");
    step(M_RYOUT,  0, 32'h0, "clr_y");
    step(M_R4OUT,  0, 32'h0, "clr_r4");

    // Clear held across a rising edge blocks a pending MDR load
    @(negedge clock);
    ctrl    = M_LDMDR;
    mdatain = 32'h55;
    clear   = 1'b1;
    @(posedge clock);
    #1 clear = 1'b0;
    step(M_MDROUT, 0, 32'h0, "clr_hold_mdr");
    step(M_LDMDR,  32'h66, 32'h0, "post_clr_ld");
    step(M_MDROUT, 0, 32'h66, "post_clr_mdr");

    @(negedge clock);
    ctrl = '0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
